// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between the instruction memory port
// and the fetch stage. Issues sequential word fetches to a variable-latency
// memory, buffers returned words with their PC and PC+4 in an in-order FIFO and
// presents the head under a valid/ready handshake. A taken branch flushes the
// queue, marks all outstanding responses stale and restarts at the target.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   imem_req_valid/ready/addr    word fetch request (addr[1:0] always 0)
//   imem_resp_valid/data         in-order responses, one per accepted request
//   take_branch, branch_target   redirect strobe and address (bits [1:0] ignored)
//   out_valid/ready              head-of-queue handshake to IF/ID
//   out_pc, out_pc_plus4, out_instr   head entry fields
//   empty                        queue holds no entries
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  entry_t        q   [DEPTH];
  logic [31:0]   tag [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] count, inflight, stale, inflight_nx;
  logic [31:0]   next_pc;
  logic [CW:0]   used;
  logic          accept, drop, push, pop;
  logic [1:0]    unused_tgt_bits;

  assign unused_tgt_bits = branch_target[1:0];

  // Entries held plus live (non-stale) requests still owed a slot.
  assign used = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(stale);

  // The all-ones guard keeps inflight from wrapping if redirects pile up stale
  // responses faster than memory returns them.
  assign imem_req_valid = !reset && !take_branch && (used < (CW+1)'(DEPTH))
                          && (inflight != {CW{1'b1}});
  assign imem_req_addr  = next_pc;

  assign accept      = imem_req_valid && imem_req_ready;
  assign drop        = imem_resp_valid && (stale != '0);
  assign push        = imem_resp_valid && (stale == '0) && !take_branch;
  assign pop         = out_valid && out_ready && !take_branch;
  assign inflight_nx = inflight + CW'(accept) - CW'(imem_resp_valid);

  assign out_valid    = (count != '0);
  assign empty        = (count == '0);
  assign out_pc       = q[rd_ptr].pc;
  assign out_pc_plus4 = q[rd_ptr].pc4;
  assign out_instr    = q[rd_ptr].instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i]   <= '0;
        tag[i] <= '0;
      end
    end else begin
      inflight <= inflight_nx;
      if (take_branch) begin
        // Everything still outstanding after this cycle is now stale. Stale
        // responses never consume tags, so the tag FIFO restarts empty.
        stale   <= inflight_nx;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        tag_rd  <= '0;
        tag_wr  <= '0;
        next_pc <= {branch_target[31:2], 2'b00};
      end else begin
        if (accept) begin
          next_pc     <= next_pc + 32'd4;
          tag[tag_wr] <= next_pc;
          tag_wr      <= tag_wr + 1'b1;
        end
        if (drop) stale <= stale - 1'b1;
        if (push) begin
          q[wr_ptr] <= '{pc: tag[tag_rd], pc4: tag[tag_rd] + 32'd4,
                         instr: imem_resp_data};
          wr_ptr    <= wr_ptr + 1'b1;
          tag_rd    <= tag_rd + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
